// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with sized loads/stores, a valid/ready
// request/response handshake, configurable wait states and error responses.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_started;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_err;
  logic [31:0]         r_rdata;
  logic                r_resp_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_commit;
  logic                w_err_in;
  logic                w_oor;
  logic [IDX_W-1:0]    w_widx;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_merge;

  assign w_accept = i_req_valid && o_req_ready;
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_widx   = r_addr[IDX_W+1:2];
  assign w_word   = r_mem[w_widx];

  // Any address bit above the word index means the word lies beyond the array.
  assign w_oor    = |(i_req_addr >> (IDX_W + 2));
  assign w_err_in = (i_req_size == 2'b11) ||
                    ((i_req_size == 2'b01) && i_req_addr[0]) ||
                    ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00)) ||
                    w_oor;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (i_resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (r_state == S_IDLE) && r_started;
    o_resp_valid = (r_state == S_RESP);
    o_resp_rdata = r_rdata;
    o_resp_err   = r_resp_err;
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_merge = w_word;
    case (r_size)
      2'b00: begin
        case (r_addr[1:0])
          2'd0:    w_merge[7:0]   = r_wdata[7:0];
          2'd1:    w_merge[15:8]  = r_wdata[7:0];
          2'd2:    w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  // Errors skip the wait states by loading a zero count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started  <= 1'b0;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_err      <= 1'b0;
      r_rdata    <= 32'd0;
      r_resp_err <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_accept) begin
        r_write    <= i_req_write;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_addr     <= i_req_addr;
        r_wdata    <= i_req_wdata;
        r_err      <= w_err_in;
        r_cnt      <= w_err_in ? 4'd0 : 4'(WAIT_STATES);
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata    <= (r_err || r_write) ? 32'd0 : w_load;
        r_resp_err <= r_err;
      end
    end
  end

  // Storage is deliberately not reset; reset forces IDLE so a pending store never commits.
  always_ff @(posedge i_clk) begin
    if (w_commit && r_write && !r_err) r_mem[w_widx] <= w_merge;
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a zero-wait-state instance and a three-wait-state
// instance share request fields; each has its own handshake signals.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;

  logic        reqValid0, reqReady0, respValid0, respReady0, respErr0;
  logic [31:0] respRdata0;
  logic        reqValid3, reqReady3, respValid3, respReady3, respErr3;
  logic [31:0] respRdata3;

  int nVectors     = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_WORDS(128), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(reqValid0), .o_req_ready(reqReady0),
    .i_req_write(reqWrite), .i_req_size(reqSize), .i_req_unsigned(reqUnsigned),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_resp_valid(respValid0), .i_resp_ready(respReady0),
    .o_resp_rdata(respRdata0), .o_resp_err(respErr0)
  );

  data_memory_ctrl #(.DEPTH_WORDS(128), .WAIT_STATES(3), .ADDR_W(32)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(reqValid3), .o_req_ready(reqReady3),
    .i_req_write(reqWrite), .i_req_size(reqSize), .i_req_unsigned(reqUnsigned),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_resp_valid(respValid3), .i_resp_ready(respReady3),
    .o_resp_rdata(respRdata3), .o_resp_err(respErr3)
  );

  typedef struct {
    bit          sel3;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit sel3, input bit wr, input logic [1:0] size,
                              input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] expData, input logic expErr, input int expLat);
    vec_t v;
    v.sel3 = sel3; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.expData = expData; v.expErr = expErr; v.expLat = expLat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s: timed out waiting for handshake", name);
  endtask

  // One full transaction: wait for ready, accept, count cycles to response, handshake.
  task automatic applyStimulus(input bit sel3, input bit wr, input logic [1:0] size,
                               input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output bit ok);
    int guard;
    ok = 1'b0; rdata = '0; err = 1'b0; lat = 0;
    @(negedge clk);
    reqWrite = wr; reqSize = size; reqUnsigned = uns; reqAddr = addr; reqWdata = wdata;
    guard = 0;
    while (!(sel3 ? reqReady3 : reqReady0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) return;
    if (sel3) reqValid3 = 1'b1; else reqValid0 = 1'b1;
    @(posedge clk); #1;
    reqValid0 = 1'b0; reqValid3 = 1'b0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (sel3 ? respValid3 : respValid0) break;
    end
    if (!(sel3 ? respValid3 : respValid0)) return;
    rdata = sel3 ? respRdata3 : respRdata0;
    err   = sel3 ? respErr3 : respErr0;
    if (sel3) respReady3 = 1'b1; else respReady0 = 1'b1;
    @(posedge clk); #1;
    respReady0 = 1'b0; respReady3 = 1'b0;
    ok = 1'b1;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          ok;
    logic [31:0] held;

    rst_n = 1'b0;
    reqValid0 = 1'b0; reqValid3 = 1'b0; respReady0 = 1'b0; respReady3 = 1'b0;
    reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0; reqAddr = '0; reqWdata = '0;

    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h10,  32'h8000_00FF, 32'h0,          0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h10,  32'h0,         32'h8000_00FF, 0, 1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0,   32'h1122_3344, 32'h0,          0, 1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h2,   32'hFFFF_FFAB, 32'h0,          0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h0,   32'h0,         32'h11AB_3344, 0, 1));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h2,   32'h0,         32'hFFFF_FFAB, 0, 1));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h2,   32'h0,         32'h0000_00AB, 0, 1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h4,   32'hCAFE_BABE, 32'h0,          0, 1));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h6,   32'h1234_8001, 32'h0,          0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h6,   32'h0,         32'hFFFF_8001, 0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h6,   32'h0,         32'h0000_8001, 0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h4,   32'h0,         32'h8001_BABE, 0, 1));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h3,   32'hFFFF_FFFF, 32'h0,          1, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h2,   32'h0,         32'h0,          1, 1));
    vecs.push_back(mk(0, 0, 2'b11, 0, 32'h0,   32'h0,         32'h0,          1, 1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h200, 32'hDEAD_BEEF, 32'h0,          1, 1));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h0,   32'h0000_0000, 32'h0,          1, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h0,   32'h0,         32'h11AB_3344, 0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h4,   32'h0,         32'h8001_BABE, 0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h4,   32'h0,         32'hFFFF_BABE, 0, 1));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h0,   32'h0,         32'h0000_0044, 0, 1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h1FC, 32'h7F00_FF01, 32'h0,          0, 1));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h1FD, 32'h0,         32'h0000_00FF, 0, 1));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h1FC, 32'h0,         32'h0000_0001, 0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h1FE, 32'h0,         32'h0000_7F00, 0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h8000_0010, 32'h0,   32'h0,          1, 1));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h20,  32'h5A5A_5A5A, 32'h0,          0, 4));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h20,  32'h0,         32'h5A5A_5A5A, 0, 4));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h21,  32'h0,         32'h0,          1, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h23,  32'h0,         32'h0000_005A, 0, 4));

    #12;
    checkOutput("reset req_ready0",  {31'd0, reqReady0},  32'd0);
    checkOutput("reset req_ready3",  {31'd0, reqReady3},  32'd0);
    checkOutput("reset resp_valid0", {31'd0, respValid0}, 32'd0);
    checkOutput("reset resp_rdata0", respRdata0,          32'd0);
    checkOutput("reset resp_err0",   {31'd0, respErr0},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready after release", {31'd0, reqReady0}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sel3, vecs[i].wr, vecs[i].size, vecs[i].uns,
                    vecs[i].addr, vecs[i].wdata, rdata, err, lat, ok);
      if (!ok) begin
        reportTimeout($sformatf("vec%0d", i));
      end else begin
        checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expData);
        checkOutput($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].expErr});
        checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      end
    end

    // Three wait states with the consumer stalling the response for five cycles.
    @(negedge clk);
    reqWrite = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0; reqAddr = 32'h20;
    checkOutput("ws3 idle ready", {31'd0, reqReady3}, 32'd1);
    reqValid3 = 1'b1;
    @(posedge clk); #1;
    reqValid3 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("ws3 wait%0d resp_valid", c), {31'd0, respValid3}, 32'd0);
      checkOutput($sformatf("ws3 wait%0d req_ready", c),  {31'd0, reqReady3},  32'd0);
    end
    @(posedge clk); #1;
    checkOutput("ws3 resp_valid at accept+4", {31'd0, respValid3}, 32'd1);
    checkOutput("ws3 rdata", respRdata3, 32'h5A5A_5A5A);
    held = respRdata3;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("ws3 hold%0d resp_valid", c), {31'd0, respValid3}, 32'd1);
      checkOutput($sformatf("ws3 hold%0d rdata", c), respRdata3, 32'h5A5A_5A5A);
      checkOutput($sformatf("ws3 hold%0d req_ready", c), {31'd0, reqReady3}, 32'd0);
    end
    respReady3 = 1'b1;
    @(posedge clk); #1;
    respReady3 = 1'b0;
    checkOutput("ws3 resp_valid drops", {31'd0, respValid3}, 32'd0);
    checkOutput("ws3 ready again", {31'd0, reqReady3}, 32'd1);
    checkOutput("ws3 err", {31'd0, respErr3}, 32'd0);

    // Reset in the middle of a pending store must leave the old word intact.
    @(negedge clk);
    reqWrite = 1'b1; reqSize = 2'b10; reqAddr = 32'h20; reqWdata = 32'h0BAD_F00D;
    reqValid3 = 1'b1;
    @(posedge clk); #1;
    reqValid3 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst in wait resp_valid3", {31'd0, respValid3}, 32'd0);
    checkOutput("rst in wait req_ready3",  {31'd0, reqReady3},  32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rst hold%0d resp_valid3", c), {31'd0, respValid3}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rdata, err, lat, ok);
    if (!ok) reportTimeout("post-reset load 0x20");
    else begin
      checkOutput("post-reset load 0x20", rdata, 32'h5A5A_5A5A);
      checkOutput("post-reset load 0x20 err", {31'd0, err}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rdata, err, lat, ok);
    if (!ok) reportTimeout("post-reset load 0x0");
    else checkOutput("post-reset load 0x0", rdata, 32'h11AB_3344);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
